pcie_ingress_buffer_sched: RTL

- Ping-pong scheduler for the host-to-device completion buffer written by the PCIe ingress parser.
- Splits one buffer RAM into two halves, A at offset 0 and B at offset BUF_DEPTH.
- Presents a ready/offset pair to the ingress parser and counts its dword writes into the active half.
- Commits a half to the downstream consumer when it fills or on a flush, and recycles it when the consumer reports done.

---
 rtl/pcie_ingress_buffer_sched.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/pcie_ingress_buffer_sched.sv
// Ping-pong scheduler for the host-to-device completion buffer: two halves of one RAM
// are filled by the ingress parser, committed to the consumer, and recycled on done.
module pcie_ingress_buffer_sched #(
    parameter int BUF_DEPTH = 1024,
    parameter int CNT_W     = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_enable,
    input  logic [31:0]      i_buffer_size,
    input  logic             i_flush,
    output logic             o_buf_rdy,
    output logic [31:0]      o_buf_offset,
    input  logic             i_buf_we,
    input  logic [31:0]      i_buf_addr,
    output logic             o_full_stb,
    output logic             o_full_sel,
    output logic [CNT_W-1:0] o_full_count,
    input  logic [1:0]       i_done,
    output logic [1:0]       o_buf_status,
    input  logic             i_clear_err,
    output logic             o_err_overflow,
    output logic             o_err_addr,
    output logic             o_err_done,
    output logic [1:0]       o_dbg_state
);

    // Handshake: the parser may write only while o_buf_rdy is high; each i_buf_we
    // cycle is one dword. o_full_stb is a single-cycle strobe with no back-pressure.

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    localparam logic [31:0]      DEPTH32 = 32'(BUF_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    state_e            state_q, state_d;
    logic              sel_q, sel_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  target_q, target_d;
    logic [1:0]        full_q, full_d;
    logic              buf_rdy_q, buf_rdy_d;
    logic [31:0]       buf_offset_q, buf_offset_d;
    logic              full_stb_q, full_stb_d;
    logic              full_sel_q, full_sel_d;
    logic [CNT_W-1:0]  full_count_q, full_count_d;
    logic              err_ovf_q, err_ovf_d;
    logic              err_addr_q, err_addr_d;
    logic              err_done_q, err_done_d;

    logic              in_range;
    logic              wr_ok;
    logic [CNT_W-1:0]  cnt_inc;
    logic [CNT_W-1:0]  eff_target;

    assign in_range   = (i_buf_addr >= buf_offset_q) && (i_buf_addr < buf_offset_q + DEPTH32);
    assign wr_ok      = i_buf_we && in_range;
    assign cnt_inc    = count_q + {{(CNT_W-1){1'b0}}, wr_ok};
    // Zero or oversized programming falls back to a full half.
    assign eff_target = ((i_buffer_size == 32'd0) || (i_buffer_size > DEPTH32)) ?
                        DEPTH_C : i_buffer_size[CNT_W-1:0];

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        count_d      = count_q;
        target_d     = target_q;
        full_d       = full_q;
        buf_offset_d = buf_offset_q;
        full_stb_d   = 1'b0;
        full_sel_d   = full_sel_q;
        full_count_d = full_count_q;
        err_ovf_d    = err_ovf_q  & ~i_clear_err;
        err_addr_d   = err_addr_q & ~i_clear_err;
        err_done_d   = err_done_q & ~i_clear_err;

        for (int n = 0; n < 2; n++) begin
            if (i_done[n]) begin
                if (!full_q[n]) err_done_d = 1'b1;
                full_d[n] = 1'b0;
            end
        end

        if (i_buf_we && (state_q != ST_FILL)) err_ovf_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                count_d = '0;
                if (i_enable && !full_q[sel_q]) begin
                    state_d  = ST_FILL;
                    target_d = eff_target;
                end
            end
            ST_FILL: begin
                if (i_buf_we && !in_range) err_addr_d = 1'b1;
                count_d = cnt_inc;
                if (wr_ok && (cnt_inc == target_q)) begin
                    state_d = ST_COMMIT;
                end else if (i_flush && (cnt_inc != '0)) begin
                    state_d = ST_COMMIT;
                end else if (!i_enable && (cnt_inc != '0)) begin
                    state_d = ST_COMMIT;
                end else if (i_flush || !i_enable) begin
                    state_d = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                // Set after the done loop so a commit wins over a same-cycle done.
                full_d[sel_q] = 1'b1;
                full_stb_d    = 1'b1;
                full_sel_d    = sel_q;
                full_count_d  = count_q;
                sel_d         = ~sel_q;
                buf_offset_d  = sel_q ? 32'd0 : DEPTH32;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        buf_rdy_d = (state_d == ST_FILL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sel_q        <= 1'b0;
            count_q      <= '0;
            target_q     <= '0;
            full_q       <= 2'b00;
            buf_rdy_q    <= 1'b0;
            buf_offset_q <= 32'd0;
            full_stb_q   <= 1'b0;
            full_sel_q   <= 1'b0;
            full_count_q <= '0;
            err_ovf_q    <= 1'b0;
            err_addr_q   <= 1'b0;
            err_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            count_q      <= count_d;
            target_q     <= target_d;
            full_q       <= full_d;
            buf_rdy_q    <= buf_rdy_d;
            buf_offset_q <= buf_offset_d;
            full_stb_q   <= full_stb_d;
            full_sel_q   <= full_sel_d;
            full_count_q <= full_count_d;
            err_ovf_q    <= err_ovf_d;
            err_addr_q   <= err_addr_d;
            err_done_q   <= err_done_d;
        end
    end

    assign o_buf_rdy      = buf_rdy_q;
    assign o_buf_offset   = buf_offset_q;
    assign o_full_stb     = full_stb_q;
    assign o_full_sel     = full_sel_q;
    assign o_full_count   = full_count_q;
    assign o_buf_status   = full_q;
    assign o_err_overflow = err_ovf_q;
    assign o_err_addr     = err_addr_q;
    assign o_err_done     = err_done_q;
    assign o_dbg_state    = state_q;

endmodule
